// File: rtl/alu_exec_pkg.sv
// Shared constants, opcode and FSM encodings for the execute/write-back stage.
// Build option: define ALU_EXEC_MUL_EN to make opcode 111 an iterative multiply.
package alu_exec_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned MUL_ITER = DATA_W;

`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpNot = 3'b101,
    OpShl = 3'b110,
    OpMul = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRead = 2'b01,
    StExec = 2'b10,
    StWb   = 2'b11
  } state_e;

  // MUL is the only opcode that depends on the build option.
  function automatic logic op_supported(op_e op);
    return (op != OpMul) || MUL_EN;
  endfunction

endpackage

// File: rtl/mul_shift_add16.sv
// 16x16 -> 32 iterative shift-add multiplier, one partial product per cycle.
// Only instantiated when ALU_EXEC_MUL_EN is defined.
// o_done is asserted during the last iteration cycle and o_product then shows
// the final sum combinationally, so the caller can capture it on that edge.
module mul_shift_add16
  import alu_exec_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_product
);

  localparam int unsigned CntW = $clog2(MUL_ITER);

  logic                r_busy;
  logic [CntW-1:0]     r_cnt;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [2*DATA_W-1:0] r_acc;

  logic [2*DATA_W-1:0] w_acc_next;
  logic                w_last;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_last     = (r_cnt == CntW'(MUL_ITER - 1));
  end

  // Iteration state: load on start, then shift once per cycle until the last bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_busy && w_last;
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_exec_unit.sv
// Single-issue execute/write-back stage for a 16-bit, 8-entry register file.
// Sequence per op: READ (drive read addresses), EXEC (compute), WB (one-cycle
// write pulse). A new op can be accepted during WB; its READ then follows the
// write edge, so it observes the freshly written value without forwarding.
// Build option: ALU_EXEC_MUL_EN enables opcode 111 (16-cycle MUL); otherwise
// opcode 111 raises op_err after EXEC with no write-back.
module alu_exec_unit #(
  parameter int unsigned DATA_W = alu_exec_pkg::DATA_W,
  parameter int unsigned ADDR_W = alu_exec_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] op_ra,
  input  logic [ADDR_W-1:0] op_rb,
  input  logic [ADDR_W-1:0] op_rd,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] d_out_a,
  input  logic [DATA_W-1:0] d_out_b,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] d_in,
  output logic              flag_z,
  output logic              flag_c,
  output logic              op_err
);
  import alu_exec_pkg::*;

  state_e              r_state;
  state_e              w_state_next;

  op_e                 r_op_code;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_d_in;
  logic                r_flag_z;
  logic                r_flag_c;
  logic                r_op_err;

  logic                w_accept;
  logic                w_unsupported;
  logic                w_exec_done;
  logic                w_wb_load;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_result;
  logic                w_carry;

  assign w_accept      = op_valid && op_ready;
  assign w_unsupported = !op_supported(r_op_code);

`ifdef ALU_EXEC_MUL_EN
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_mul_product;

  // Operands go straight from the register file so the multiply starts on the
  // same edge the ALU operands are captured.
  assign w_mul_start = (r_state == StRead) && (r_op_code == OpMul);

  mul_shift_add16 u_mul (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_start   (w_mul_start),
    .i_a       (d_out_a),
    .i_b       (d_out_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  assign w_exec_done = (r_op_code == OpMul) ? w_mul_done : 1'b1;
`else
  assign w_exec_done = 1'b1;
`endif

  assign w_wb_load = (r_state == StExec) && w_exec_done && !w_unsupported;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_next = StRead;
      StRead: w_state_next = StExec;
      StExec: begin
        if (w_unsupported) begin
          w_state_next = StIdle;
        end else if (w_exec_done) begin
          w_state_next = StWb;
        end
      end
      StWb:   w_state_next = w_accept ? StRead : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: handshake and write strobe follow the state directly, so an
  // asynchronous reset kills a pending write immediately.
  always_comb begin
    op_ready = (r_state == StIdle) || (r_state == StWb);
    wr       = (r_state == StWb);
  end

  // ALU: result and carry for the latched opcode and captured operands.
  always_comb begin
    w_sum    = '0;
    w_result = '0;
    w_carry  = 1'b0;
    unique case (r_op_code)
      OpAdd: begin
        w_sum    = {1'b0, r_op_a} + {1'b0, r_op_b};
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
      end
      OpSub: begin
        w_result = r_op_a - r_op_b;
        w_carry  = (r_op_a < r_op_b);
      end
      OpAnd: w_result = r_op_a & r_op_b;
      OpOr:  w_result = r_op_a | r_op_b;
      OpXor: w_result = r_op_a ^ r_op_b;
      OpNot: w_result = ~r_op_a;
      OpShl: begin
        w_result = {r_op_a[DATA_W-2:0], 1'b0};
        w_carry  = r_op_a[DATA_W-1];
      end
      OpMul: begin
`ifdef ALU_EXEC_MUL_EN
        w_result = w_mul_product[DATA_W-1:0];
        w_carry  = |w_mul_product[2*DATA_W-1:DATA_W];
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers: request latch, operand capture, write-back and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_code <= OpAdd;
      r_rd      <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_wr_addr <= '0;
      r_d_in    <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_op_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_code <= op_e'(op_code);
        r_rd      <= op_rd;
        r_addr_a  <= op_ra;
        r_addr_b  <= op_rb;
      end
      if (r_state == StRead) begin
        r_op_a <= d_out_a;
        r_op_b <= d_out_b;
      end
      if (w_wb_load) begin
        r_wr_addr <= r_rd;
        r_d_in    <= w_result;
        r_flag_z  <= (w_result == '0);
        r_flag_c  <= w_carry;
      end
      r_op_err <= (r_state == StExec) && w_unsupported;
    end
  end

  assign rd_addr_a = r_addr_a;
  assign rd_addr_b = r_addr_b;
  assign wr_addr   = r_wr_addr;
  assign d_in      = r_d_in;
  assign flag_z    = r_flag_z;
  assign flag_c    = r_flag_c;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a small register-file model.
// Covers ALU ops, back-to-back issue and reset abort; MUL or op_err checks
// depend on whether ALU_EXEC_MUL_EN is defined.
module tb_alu_exec_unit;

  localparam logic [2:0] C_ADD = 3'b000;
  localparam logic [2:0] C_SUB = 3'b001;
  localparam logic [2:0] C_AND = 3'b010;
  localparam logic [2:0] C_OR  = 3'b011;
  localparam logic [2:0] C_XOR = 3'b100;
  localparam logic [2:0] C_NOT = 3'b101;
  localparam logic [2:0] C_SHL = 3'b110;
  localparam logic [2:0] C_MUL = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [2:0]  op_ra, op_rb, op_rd;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] d_out_a, d_out_b;
  logic        wr;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        flag_z, flag_c, op_err;

  logic [15:0] rf [8];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_ra     (op_ra),
    .op_rb     (op_rb),
    .op_rd     (op_rd),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b),
    .wr        (wr),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .op_err    (op_err)
  );

  assign d_out_a = rf[rd_addr_a];
  assign d_out_b = rf[rd_addr_b];

  always @(posedge clk) begin
    if (wr) rf[wr_addr] <= d_in;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Presents one request while idle; returns 1ns after the accept edge.
  task automatic issue(input logic [2:0] c, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rd);
    op_code = c; op_ra = ra; op_rb = rb; op_rd = rd; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; op_valid = 1'b0; op_code = '0; op_ra = '0; op_rb = '0; op_rd = '0;
    tick(); tick();
    n_vec++;
    if ({op_ready, wr, op_err} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctl: got ready/wr/err=%b want 100", {op_ready, wr, op_err});
    end
    n_vec++;
    if ({rd_addr_a, rd_addr_b, wr_addr} !== 9'd0) begin
      n_err++; $display("FAIL reset_addr: got %h/%h/%h want 0", rd_addr_a, rd_addr_b, wr_addr);
    end
    n_vec++;
    if ({d_in, flag_z, flag_c} !== 18'd0) begin
      n_err++; $display("FAIL reset_data: got d_in=%h z=%b c=%b want 0", d_in, flag_z, flag_c);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add_basic;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    issue(C_ADD, 3'd1, 3'd2, 3'd3);
    n_vec++;
    if ({op_ready, wr, rd_addr_a, rd_addr_b} !== {1'b0, 1'b0, 3'd1, 3'd2}) begin
      n_err++; $display("FAIL add_read: got ready=%b wr=%b a=%0d b=%0d want 0 0 1 2",
                        op_ready, wr, rd_addr_a, rd_addr_b);
    end
    tick();
    n_vec++;
    if ({op_ready, wr} !== 2'b00) begin
      n_err++; $display("FAIL add_exec: got ready/wr=%b want 00", {op_ready, wr});
    end
    tick();
    n_vec++;
    if ({wr, op_ready, wr_addr, d_in, flag_z, flag_c} !== {2'b11, 3'd3, 16'h0008, 2'b00}) begin
      n_err++; $display("FAIL add_wb: got wr=%b rdy=%b addr=%0d d=%h z=%b c=%b want 1 1 3 0008 0 0",
                        wr, op_ready, wr_addr, d_in, flag_z, flag_c);
    end
    tick();
    n_vec++;
    if ({wr, d_in, rf[3]} !== {1'b0, 16'h0008, 16'h0008}) begin
      n_err++; $display("FAIL add_after: got wr=%b d_in=%h r3=%h want 0 0008 0008", wr, d_in, rf[3]);
    end
  endtask

  task automatic test_arith;
    logic [2:0]  c, ra, rb;
    logic [15:0] ed;
    logic        ez, ec;
    preload(3'd4, 16'hFFFF);
    preload(3'd5, 16'h0001);
    preload(3'd6, 16'h8001);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin c = C_ADD; ra = 3'd4; rb = 3'd5; ed = 16'h0000; ez = 1'b1; ec = 1'b1; end
        1: begin c = C_SUB; ra = 3'd2; rb = 3'd1; ed = 16'hFFFE; ez = 1'b0; ec = 1'b1; end
        2: begin c = C_SHL; ra = 3'd6; rb = 3'd0; ed = 16'h0002; ez = 1'b0; ec = 1'b1; end
        3: begin c = C_NOT; ra = 3'd4; rb = 3'd0; ed = 16'h0000; ez = 1'b1; ec = 1'b0; end
        4: begin c = C_AND; ra = 3'd4; rb = 3'd6; ed = 16'h8001; ez = 1'b0; ec = 1'b0; end
        default: begin c = C_OR; ra = 3'd1; rb = 3'd2; ed = 16'h0007; ez = 1'b0; ec = 1'b0; end
      endcase
      issue(c, ra, rb, 3'd7);
      tick(); tick();
      n_vec++;
      if ({wr, wr_addr, d_in, flag_z, flag_c} !== {1'b1, 3'd7, ed, ez, ec}) begin
        n_err++; $display("FAIL arith_%0d: got wr=%b addr=%0d d=%h z=%b c=%b want 1 7 %h %b %b",
                          i, wr, wr_addr, d_in, flag_z, flag_c, ed, ez, ec);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    op_code = C_ADD; op_ra = 3'd1; op_rb = 3'd2; op_rd = 3'd3; op_valid = 1'b1;
    tick();
    op_code = C_XOR; op_ra = 3'd3; op_rb = 3'd1; op_rd = 3'd4;
    n_vec++;
    if ({op_ready, rd_addr_a} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL b2b_n0: got ready=%b a=%0d want 0 1", op_ready, rd_addr_a);
    end
    tick();
    n_vec++;
    if ({op_ready, rd_addr_a, rd_addr_b} !== {1'b0, 3'd1, 3'd2}) begin
      n_err++; $display("FAIL b2b_n1: got ready=%b a=%0d b=%0d want 0 1 2",
                        op_ready, rd_addr_a, rd_addr_b);
    end
    tick();
    n_vec++;
    if ({wr, op_ready, wr_addr, d_in} !== {2'b11, 3'd3, 16'h0008}) begin
      n_err++; $display("FAIL b2b_wb1: got wr=%b rdy=%b addr=%0d d=%h want 1 1 3 0008",
                        wr, op_ready, wr_addr, d_in);
    end
    tick();
    op_valid = 1'b0;
    n_vec++;
    if ({wr, op_ready, rd_addr_a, rd_addr_b} !== {2'b00, 3'd3, 3'd1}) begin
      n_err++; $display("FAIL b2b_n3: got wr=%b rdy=%b a=%0d b=%0d want 0 0 3 1",
                        wr, op_ready, rd_addr_a, rd_addr_b);
    end
    tick();
    n_vec++;
    if (wr !== 1'b0) begin
      n_err++; $display("FAIL b2b_n4: got wr=%b want 0", wr);
    end
    tick();
    n_vec++;
    if ({wr, wr_addr, d_in} !== {1'b1, 3'd4, 16'h000D}) begin
      n_err++; $display("FAIL b2b_wb2: got wr=%b addr=%0d d=%h want 1 4 000d", wr, wr_addr, d_in);
    end
    tick();
    n_vec++;
    if ({wr, op_ready, rf[4]} !== {2'b01, 16'h000D}) begin
      n_err++; $display("FAIL b2b_n6: got wr=%b rdy=%b r4=%h want 0 1 000d", wr, op_ready, rf[4]);
    end
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul;
    logic bad;
    preload(3'd1, 16'h0100);
    preload(3'd2, 16'h0007);
    preload(3'd3, 16'h0009);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(C_MUL, 3'd1, 3'd1, 3'd5);
      else        issue(C_MUL, 3'd2, 3'd3, 3'd5);
      bad = 1'b0;
      for (int i = 0; i < 17; i++) begin
        if (op_ready !== 1'b0 || wr !== 1'b0) bad = 1'b1;
        tick();
      end
      n_vec++;
      if (bad) begin
        n_err++; $display("FAIL mul_busy_%0d: got ready/wr active within 17 cycles want idle", k);
      end
      n_vec++;
      if (k == 0 && {wr, op_ready, d_in, flag_z, flag_c} !== {2'b11, 16'h0000, 2'b11}) begin
        n_err++; $display("FAIL mul_wb_0: got wr=%b rdy=%b d=%h z=%b c=%b want 1 1 0000 1 1",
                          wr, op_ready, d_in, flag_z, flag_c);
      end
      if (k == 1 && {wr, d_in, flag_z, flag_c} !== {1'b1, 16'h003F, 2'b00}) begin
        n_err++; $display("FAIL mul_wb_1: got wr=%b d=%h z=%b c=%b want 1 003f 0 0",
                          wr, d_in, flag_z, flag_c);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mul;
    logic saw_wr;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    issue(C_MUL, 3'd1, 3'd2, 3'd6);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if ({op_ready, wr, op_err, rd_addr_a, rd_addr_b, wr_addr, d_in, flag_z, flag_c} !==
        {3'b100, 9'd0, 16'h0000, 2'b00}) begin
      n_err++; $display("FAIL rstmul_out: got rdy=%b wr=%b err=%b a=%0d b=%0d wa=%0d d=%h z=%b c=%b",
                        op_ready, wr, op_err, rd_addr_a, rd_addr_b, wr_addr, d_in, flag_z, flag_c);
    end
    tick(); tick();
    reset = 1'b1;
    saw_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr !== 1'b0) saw_wr = 1'b1;
    end
    n_vec++;
    if (saw_wr || op_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmul_quiet: got saw_wr=%b ready=%b want 0 1", saw_wr, op_ready);
    end
    issue(C_ADD, 3'd1, 3'd2, 3'd6);
    tick(); tick();
    n_vec++;
    if ({wr, wr_addr, d_in} !== {1'b1, 3'd6, 16'h0008}) begin
      n_err++; $display("FAIL rstmul_add: got wr=%b addr=%0d d=%h want 1 6 0008", wr, wr_addr, d_in);
    end
    tick();
  endtask
`else
  task automatic test_op_err;
    logic saw_wr;
    preload(3'd4, 16'hFFFF);
    preload(3'd5, 16'h0001);
    issue(C_ADD, 3'd4, 3'd5, 3'd7);
    tick(); tick(); tick();
    saw_wr = 1'b0;
    issue(C_MUL, 3'd1, 3'd2, 3'd6);
    n_vec++;
    if (op_err !== 1'b0) begin
      n_err++; $display("FAIL err_n0: got op_err=%b want 0", op_err);
    end
    if (wr !== 1'b0) saw_wr = 1'b1;
    tick();
    n_vec++;
    if ({op_err, op_ready} !== 2'b00) begin
      n_err++; $display("FAIL err_n1: got err/ready=%b want 00", {op_err, op_ready});
    end
    if (wr !== 1'b0) saw_wr = 1'b1;
    tick();
    n_vec++;
    if ({op_err, op_ready, flag_z, flag_c, d_in, wr_addr} !== {4'b1111, 16'h0000, 3'd7}) begin
      n_err++; $display("FAIL err_n2: got err=%b rdy=%b z=%b c=%b d=%h wa=%0d want 1 1 1 1 0000 7",
                        op_err, op_ready, flag_z, flag_c, d_in, wr_addr);
    end
    if (wr !== 1'b0) saw_wr = 1'b1;
    tick();
    n_vec++;
    if ({op_err, op_ready} !== 2'b01) begin
      n_err++; $display("FAIL err_n3: got err/ready=%b want 01", {op_err, op_ready});
    end
    for (int i = 0; i < 4; i++) begin
      if (wr !== 1'b0) saw_wr = 1'b1;
      tick();
    end
    n_vec++;
    if (saw_wr) begin
      n_err++; $display("FAIL err_nowr: got wr asserted want never");
    end
  endtask
`endif

  task automatic test_reset_in_wb;
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    preload(3'd7, 16'hAAAA);
    issue(C_ADD, 3'd1, 3'd2, 3'd7);
    tick(); tick();
    n_vec++;
    if (wr !== 1'b1) begin
      n_err++; $display("FAIL rstwb_pre: got wr=%b want 1", wr);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({wr, op_ready, d_in, wr_addr, flag_z, flag_c} !== {2'b01, 16'h0000, 3'd0, 2'b00}) begin
      n_err++; $display("FAIL rstwb_out: got wr=%b rdy=%b d=%h wa=%0d z=%b c=%b want 0 1 0 0 0 0",
                        wr, op_ready, d_in, wr_addr, flag_z, flag_c);
    end
    tick();
    reset = 1'b1;
    tick(); tick();
    n_vec++;
    if (rf[7] !== 16'hAAAA) begin
      n_err++; $display("FAIL rstwb_nowrite: got r7=%h want aaaa", rf[7]);
    end
    issue(C_ADD, 3'd1, 3'd2, 3'd7);
    tick(); tick(); tick();
    n_vec++;
    if (rf[7] !== 16'h0008) begin
      n_err++; $display("FAIL rstwb_recover: got r7=%h want 0008", rf[7]);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_arith();
`ifdef ALU_EXEC_MUL_EN
    test_mul();
`else
    test_op_err();
`endif
    test_back_to_back();
    test_reset_in_wb();
`ifdef ALU_EXEC_MUL_EN
    test_reset_mid_mul();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Single-issue execute/write-back stage for the 16-bit, 8-entry register file. It accepts one operation at a time over a valid/ready handshake and drives the register file's two read addresses. It captures the returned operands, computes the result, and drives the register file write port (`wr`, `wr_addr`, `d_in`) for exactly one cycle. It also maintains zero/carry flags.

## Interface
- `DATA_W`, 16, datapath width; fixed at 16 for register-file compatibility
- `ADDR_W`, 3, register address width; fixed at 3 (8 registers)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; top level inverts it for the register file's active-high reset
- `op_valid`  in  1  operation request
- `op_ready`  out  1  stage can accept
- `op_code`  in  3  operation select
- `op_ra`, `op_rb`, `op_rd`  in  3 each  source A, source B, destination register
- `rd_addr_a`, `rd_addr_b`  out  3 each  register-file read addresses
- `d_out_a`, `d_out_b`  in  16 each  register-file read data (combinational)
- `wr`  out  1  register-file write enable, one-cycle pulse
- `wr_addr`  out  3  write address
- `d_in`  out  16  write data
- `flag_z`, `flag_c`  out  1 each  zero/carry from the last written result
- `op_err`  out  1  one-cycle pulse for an unsupported opcode

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB (a−b)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT a
  - 110 SHL a by 1
  - 111 MUL (low 16 bits of a×b)
- Accept: a transfer occurs on a rising edge with `op_valid`&&`op_ready`. On that edge `op_code` and `op_rd` are latched, and `op_ra`/`op_rb` are latched into `rd_addr_a`/`rd_addr_b`. Inputs are ignored at all other edges.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE→READ on accept.
  - READ→EXEC unconditionally; operands are captured from `d_out_a`/`d_out_b` on the READ→EXEC edge.
  - EXEC→WB after 1 cycle for ALU ops, or after 16 cycles for MUL.
  - EXEC→IDLE for an unsupported opcode.
  - WB→READ if a new op is accepted in WB, else WB→IDLE.
- `op_ready` = 1 in IDLE and WB, 0 in READ and EXEC.
- WB: `wr`=1 for exactly one cycle; `wr_addr`=latched rd; `d_in`=result; flags update on entry to WB.
  - `wr_addr` and `d_in` hold their values until the next WB.
- Arithmetic (all results mod 2^16; Z = result==0):
  - ADD: C = carry out of bit 15.
  - SUB: C = borrow (a<b unsigned).
  - AND, OR, XOR, NOT: C=0.
  - SHL: C = a[15], bit 0 = 0.
  - MUL: C = 1 if the upper 16 product bits are nonzero.
- Hazard freedom: an op accepted in WB does its READ after the write edge, so it sees the just-written value. No forwarding logic is required.
- `op_err`: one-cycle pulse on the EXEC→IDLE transition for an unsupported opcode. `wr` stays 0 and the flags are unchanged.

## Timing
- Let the accept edge be N:
  - READ occupies N..N+1.
  - EXEC occupies N+1..N+2 for ALU ops.
  - WB (`wr`=1) occupies N+2..N+3; the register file latches at N+3.
- MUL: EXEC spans N+1..N+17 and WB spans N+17..N+18.
- Peak throughput: one ALU op per 3 cycles. The next op may be accepted at edge N+3 (while in WB).
- Reset (asynchronous assert, synchronous release):
  - State → IDLE.
  - `op_ready`=1, `wr`=0, `op_err`=0.
  - `rd_addr_a`/`rd_addr_b`/`wr_addr`=0, `d_in`=0x0000, `flag_z`=`flag_c`=0.
  - Operand and multiplier registers are cleared.
  - An in-flight op is discarded with no write, including reset asserted during WB.
- `op_valid` may drop before accept without penalty. There is no requirement for `op_valid` to stay stable while `op_ready`=0.

## Configuration
- `ALU_EXEC_MUL_EN` defined: opcode 111 = MUL, using a 16-cycle iterative shift-add multiplier.
- Undefined: no multiplier logic is instantiated. Opcode 111 is unsupported: READ and EXEC still take one cycle each, then `op_err` pulses at N+2, with no WB and no flag update.

## Structure
- Package `alu_exec_pkg`:
  - `DATA_W`/`ADDR_W` constants.
  - Opcode constants.
  - FSM state enum.
  - MUL iteration count (= `DATA_W`).
- Sub-module `mul_shift_add16`: start/done handshake, 16 iterations, 32-bit product; instantiated only under `ALU_EXEC_MUL_EN`.

## Test plan
- Bench register file preloaded r1=0x0005, r2=0x0003; ADD ra=1 rb=2 rd=3 accepted at edge N -> `wr`=1 only during N+2..N+3, `wr_addr`=3, `d_in`=0x0008, Z=0, C=0.
- ADD 0xFFFF+0x0001 -> `d_in`=0x0000, Z=1, C=1; SUB 0x0003−0x0005 -> 0xFFFE, C=1; SHL 0x8001 -> 0x0002, C=1.
- Back-to-back: ADD r3=r1+r2, then XOR r4=r3^r1 held valid -> second op accepted in the first op's WB cycle; r4 write `d_in`=0x000D at N+5..N+6.
- With `ALU_EXEC_MUL_EN`: MUL 0x0100×0x0100 -> `op_ready`=0 for 17 cycles, `wr` at N+17, `d_in`=0x0000, Z=1, C=1; MUL 0x0007×0x0009 -> 0x003F, C=0.
- Without `ALU_EXEC_MUL_EN`: opcode 111 -> `op_err` pulse at N+2..N+3, `wr` never asserted, flags unchanged, `op_ready`=1 at N+3.
- Reset asserted mid-MUL (EXEC cycle 5) -> all outputs take their reset values immediately, no write ever issued, `op_ready`=1 after release, and the next ADD completes normally.
